// File: rtl/integral_image_builder.sv
// Integral image builder: accumulates one raster-order grayscale window into a
// registered summed-area table and raises START once the window is complete.
module integral_image_builder #(
    parameter int unsigned WIN_W = 20,
    parameter int unsigned WIN_H = 20,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned II_W  = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic             pix_ready,
    input  logic             release_win,
    output logic [II_W-1:0]  integral_buffer [WIN_W*WIN_H],
    output logic             START,
    output logic             busy,
    output logic             sof_error
);

    localparam int unsigned N  = WIN_W * WIN_H;
    localparam int unsigned XW = $clog2(WIN_W);
    localparam int unsigned YW = $clog2(WIN_H);
    localparam int unsigned AW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [II_W-1:0] row_sum_q, row_sum_d;
    logic            sof_error_q, sof_error_d;
    logic [II_W-1:0] ii_q [N];
    logic [II_W-1:0] ii_d [N];

    logic            xfer;
    logic            wr_en;
    logic            frame_end;
    logic [XW-1:0]   eff_x;
    logic [YW-1:0]   eff_y;
    logic            last_x;
    logic            last_y;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   up_addr;
    logic [II_W-1:0] row_new;
    logic [II_W-1:0] wr_data;

    // State register and datapath flops
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            row_sum_q   <= '0;
            sof_error_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                ii_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            row_sum_q   <= row_sum_d;
            sof_error_q <= sof_error_d;
            ii_q        <= ii_d;
        end
    end

    // A sof pixel always lands at (0,0), whether it opens or restarts a window
    always_comb begin
        xfer      = pix_valid && pix_ready;
        wr_en     = xfer && ((state_q == ACCUM) || (state_q == IDLE && pix_sof));
        eff_x     = pix_sof ? '0 : x_q;
        eff_y     = pix_sof ? '0 : y_q;
        last_x    = (eff_x == XW'(WIN_W - 1));
        last_y    = (eff_y == YW'(WIN_H - 1));
        frame_end = wr_en && last_x && last_y;
        wr_addr   = AW'(32'(eff_y) * WIN_W + 32'(eff_x));
        up_addr   = wr_addr - AW'(WIN_W);
        row_new   = ((eff_x == '0) ? '0 : row_sum_q) + II_W'(pix_in);
        wr_data   = row_new + ((eff_y == '0) ? '0 : ii_q[up_addr]);

        x_d         = x_q;
        y_d         = y_q;
        row_sum_d   = row_sum_q;
        ii_d        = ii_q;
        sof_error_d = xfer && (((state_q == IDLE) && !pix_sof) ||
                               ((state_q == ACCUM) && pix_sof));
        if (wr_en) begin
            row_sum_d     = row_new;
            ii_d[wr_addr] = wr_data;
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : eff_y + YW'(1);
            end else begin
                x_d = eff_x + XW'(1);
                y_d = eff_y;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (xfer && pix_sof) state_d = ACCUM;
            ACCUM:   if (frame_end)       state_d = DONE;
            DONE:    if (release_win)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        pix_ready       = !Reset && (state_q != DONE);
        busy            = (state_q == ACCUM);
        START           = (state_q == DONE);
        sof_error       = sof_error_q;
        integral_buffer = ii_q;
    end

endmodule

// File: tb/tb_integral_image_builder.sv
// Self-checking bench for integral_image_builder: table-driven frames and spot
// values, plus directed sequences for DONE hold, release, IDLE discard and reset.
module tb_integral_image_builder;

    localparam int N = 400;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic        release_win;
    logic [31:0] ibuf [N];
    logic        START;
    logic        busy;
    logic        sof_error;

    integral_image_builder #(
        .WIN_W(20),
        .WIN_H(20),
        .PIX_W(8),
        .II_W (32)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .pix_in         (pix_in),
        .pix_valid      (pix_valid),
        .pix_sof        (pix_sof),
        .pix_ready      (pix_ready),
        .release_win    (release_win),
        .integral_buffer(ibuf),
        .START          (START),
        .busy           (busy),
        .sof_error      (sof_error)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_err = 0;
    int          sof_err_cnt = 0;
    logic        track_busy;
    logic        busy_bad;
    logic [31:0] exp_ii [N];

    // sof_error is registered; sample it shortly after each rising edge
    always @(posedge Clk) begin
        #2;
        if (sof_error === 1'b1) sof_err_cnt++;
    end

    typedef struct {
        int kind;      // 0 ones, 1 all-255, 2 x+y
        int gap;       // max idle cycles before each pixel
        int restart;   // pixels sent before the sof restart (0 = none)
        int sof_errs;  // expected sof_error pulses
    } frame_t;

    typedef struct {
        int sc;
        int idx;
        int expv;
    } spot_t;

    frame_t frames [4];
    spot_t  spots  [16];

    function automatic int pat(input int kind, input int x, input int y);
        case (kind)
            0:       return 1;
            1:       return 255;
            default: return x + y;
        endcase
    endfunction

    // Reference: direct rectangle sum, independent of the recurrence
    task automatic build_model(input int kind);
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < 20; x++) begin
                int s;
                s = 0;
                for (int j = 0; j <= y; j++)
                    for (int i = 0; i <= x; i++)
                        s += pat(kind, i, j);
                exp_ii[y*20+x] = 32'(s);
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) exp_ii[i] = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_buf(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < N; i++)
            if (ibuf[i] !== exp_ii[i] && bad < 0) bad = i;
        if (bad >= 0) begin
            $display("first buffer difference at index %0d", bad);
            chk(name, 64'(ibuf[bad]), 64'(exp_ii[bad]));
        end else begin
            chk(name, 64'(ibuf[N-1]), 64'(exp_ii[N-1]));
        end
    endtask

    task automatic send_px(input logic [7:0] p, input logic sof, input int gapmax);
        int g;
        int n;
        g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        pix_valid = 1'b0;
        repeat (g) @(negedge Clk);
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = 1'b1;
        n = 0;
        while (pix_ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(pix_ready), 64'd1);
        if (track_busy && busy !== 1'b1) busy_bad = 1'b1;
        @(negedge Clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int gap, input int restart);
        track_busy = 1'b0;
        busy_bad   = 1'b0;
        for (int k = 0; k < restart; k++) begin
            send_px(8'(pat(2, k % 20, k / 20)), k == 0, gap);
            track_busy = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) chk("start_before_last", 64'(START), 64'd0);
            send_px(8'(pat(kind, k % 20, k / 20)), k == 0, gap);
            track_busy = 1'b1;
        end
        chk("start_after_last", 64'(START), 64'd1);
        chk("busy_during_frame", 64'(busy_bad), 64'd0);
        chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic release_window();
        release_win = 1'b1;
        @(negedge Clk);
        release_win = 1'b0;
        chk("start_after_release", 64'(START), 64'd0);
        chk("busy_after_release", 64'(busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   e0;
        logic rdy_seen;
        logic [14:0] hi_or;

        frames[0] = '{kind: 0, gap: 0, restart: 0,  sof_errs: 0};
        frames[1] = '{kind: 1, gap: 0, restart: 0,  sof_errs: 0};
        frames[2] = '{kind: 2, gap: 3, restart: 0,  sof_errs: 0};
        frames[3] = '{kind: 0, gap: 0, restart: 57, sof_errs: 1};

        spots[0]  = '{sc: 0, idx: 0,   expv: 1};
        spots[1]  = '{sc: 0, idx: 19,  expv: 20};
        spots[2]  = '{sc: 0, idx: 20,  expv: 2};
        spots[3]  = '{sc: 0, idx: 42,  expv: 9};
        spots[4]  = '{sc: 0, idx: 399, expv: 400};
        spots[5]  = '{sc: 1, idx: 0,   expv: 255};
        spots[6]  = '{sc: 1, idx: 19,  expv: 5100};
        spots[7]  = '{sc: 1, idx: 20,  expv: 510};
        spots[8]  = '{sc: 1, idx: 399, expv: 102000};
        spots[9]  = '{sc: 2, idx: 19,  expv: 190};
        spots[10] = '{sc: 2, idx: 20,  expv: 1};
        spots[11] = '{sc: 2, idx: 21,  expv: 4};
        spots[12] = '{sc: 2, idx: 399, expv: 7600};
        spots[13] = '{sc: 3, idx: 57,  expv: 54};
        spots[14] = '{sc: 3, idx: 399, expv: 400};
        spots[15] = '{sc: 3, idx: 0,   expv: 1};

        Reset       = 1'b1;
        pix_in      = '0;
        pix_valid   = 1'b0;
        pix_sof     = 1'b0;
        release_win = 1'b0;
        track_busy  = 1'b0;
        busy_bad    = 1'b0;

        repeat (3) @(negedge Clk);
        clear_model();
        chk("reset_pix_ready", 64'(pix_ready), 64'd0);
        chk("reset_start", 64'(START), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_sof_error", 64'(sof_error), 64'd0);
        check_buf("reset_buf");
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle_pix_ready", 64'(pix_ready), 64'd1);

        for (int s = 0; s < 4; s++) begin
            e0 = sof_err_cnt;
            build_model(frames[s].kind);
            send_frame(frames[s].kind, frames[s].gap, frames[s].restart);
            check_buf($sformatf("frame%0d_buf", s));
            foreach (spots[i])
                if (spots[i].sc == s)
                    chk($sformatf("frame%0d_ii%0d", s, spots[i].idx),
                        64'(ibuf[spots[i].idx]), 64'(spots[i].expv));
            if (frames[s].kind == 1) begin
                hi_or = '0;
                for (int i = 0; i < N; i++) hi_or |= ibuf[i][31:17];
                chk("upper_bits_zero", 64'(hi_or), 64'd0);
            end
            if (s < 3) release_window();
            @(negedge Clk);
            @(negedge Clk);
            chk($sformatf("frame%0d_sof_err", s), 64'(sof_err_cnt - e0),
                64'(frames[s].sof_errs));
        end

        // DONE holds: offered pixels are refused and the buffer stays frozen
        e0 = sof_err_cnt;
        pix_in    = 8'd99;
        pix_sof   = 1'b1;
        pix_valid = 1'b1;
        rdy_seen  = (pix_ready !== 1'b0);
        repeat (10) begin
            @(negedge Clk);
            if (pix_ready !== 1'b0) rdy_seen = 1'b1;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        chk("done_no_ready", 64'(rdy_seen), 64'd0);
        chk("done_start_held", 64'(START), 64'd1);
        check_buf("done_buf_frozen");
        release_window();
        @(negedge Clk);
        chk("done_no_sof_err", 64'(sof_err_cnt - e0), 64'd0);

        // Non-sof pixel in IDLE is discarded with an error pulse
        e0 = sof_err_cnt;
        track_busy = 1'b0;
        send_px(8'd7, 1'b0, 0);
        @(negedge Clk);
        @(negedge Clk);
        chk("idle_stray_sof_err", 64'(sof_err_cnt - e0), 64'd1);
        chk("idle_stray_busy", 64'(busy), 64'd0);
        chk("idle_stray_ii0", 64'(ibuf[0]), 64'd1);
        chk("idle_stray_ready", 64'(pix_ready), 64'd1);

        // Reset mid-frame clears everything
        track_busy = 1'b0;
        for (int k = 0; k < 100; k++) send_px(8'd1, k == 0, 0);
        chk("midframe_busy", 64'(busy), 64'd1);
        Reset = 1'b1;
        #1;
        chk("reset_mid_ready", 64'(pix_ready), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        clear_model();
        chk("reset_mid_start", 64'(START), 64'd0);
        chk("reset_mid_busy", 64'(busy), 64'd0);
        check_buf("reset_mid_buf");
        @(negedge Clk);
        build_model(0);
        send_frame(0, 0, 0);
        check_buf("after_reset_buf");
        chk("after_reset_ii399", 64'(ibuf[399]), 64'd400);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
